// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizing for the 2-read/1-write register file.
// Contents:
//   rf_state_t     - sweep FSM state (CLEAR zeroes storage, IDLE is normal use)
//   RF_*           - default parameters used by the datapath top
//   addr_in_range  - true when an address selects an implemented register
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W     = 16;
  localparam int RF_NUM_REGS   = 8;
  localparam int RF_RESULT_IDX = 3;
  localparam int RF_BYPASS     = 1;

  // Non-power-of-two depths leave holes at the top of the address space.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] num_regs);
    return (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of regfile_2r1w.
// Ports:
//   i_ready                 - file is in IDLE; all outputs are forced to 0 otherwise
//   i_rd_en / i_rd_addr     - read request
//   i_mem_flat / i_busy     - flattened storage and pending-write scoreboard
//   i_wr_en/_addr/_data     - same-cycle write, forwarded when BYPASS is set
//   i_rsv_en / i_rsv_addr   - same-cycle reserve (keeps a bypassed read busy)
//   o_rd_data / o_busy      - read data (0 when disabled) and pending flag
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = RF_BYPASS
) (
  input  logic                       i_ready,
  input  logic                       i_rd_en,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  input  logic [NUM_REGS*DATA_W-1:0] i_mem_flat,
  input  logic [NUM_REGS-1:0]        i_busy,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rsv_en,
  input  logic [ADDR_W-1:0]          i_rsv_addr,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_busy
);

  localparam bit BYP_EN = (BYPASS != 32'sd0);

  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_wr_hit;
  logic              w_rsv_hit;
  logic [DATA_W-1:0] w_stored;

  // Decode, range check, bypass selection and enable gating.
  always_comb begin
    w_in_range = addr_in_range(32'(i_rd_addr), 32'(NUM_REGS));
    // Out-of-range addresses are steered to entry 0 so the select stays inside the vector.
    w_idx      = w_in_range ? i_rd_addr : '0;
    w_wr_hit   = BYP_EN && i_wr_en && (i_wr_addr == i_rd_addr);
    w_rsv_hit  = i_rsv_en && (i_rsv_addr == i_rd_addr);
    w_stored   = i_mem_flat[w_idx*DATA_W +: DATA_W];
    if (!i_ready || !w_in_range) begin
      o_rd_data = '0;
      o_busy    = 1'b0;
    end else if (w_wr_hit) begin
      // Forwarded write clears pending, but a coincident reserve wins.
      o_rd_data = i_rd_en ? i_wr_data : '0;
      o_busy    = w_rsv_hit;
    end else begin
      o_rd_data = i_rd_en ? w_stored : '0;
      o_busy    = i_busy[w_idx];
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file, two combinational read ports, one
// write port, pending-write scoreboard and a zeroing sweep after reset/clr_req.
// Ports:
//   clk, reset                     - rising-edge clock, synchronous active-high reset
//   wr_en / wr_addr / wr_data      - write port (IDLE only)
//   rd_en_x / rd_addr_x            - read port A/B request
//   rd_data_x / busy_x             - read port A/B data and pending flag
//   rsv_en / rsv_addr              - mark a register pending (IDLE only)
//   clr_req                        - start a clear sweep (IDLE only)
//   ready                          - 1 in IDLE, 0 during the sweep
//   result                         - fixed tap of register RESULT_IDX
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ADDR_W     = $clog2(NUM_REGS),
  parameter int RESULT_IDX = RF_RESULT_IDX,
  parameter int BYPASS     = RF_BYPASS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              busy_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              ready,
  output logic [DATA_W-1:0] result
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  rf_state_t                  r_state;
  logic [ADDR_W-1:0]          r_ptr;
  logic [DATA_W-1:0]          r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]        r_busy;
  logic [NUM_REGS*DATA_W-1:0] w_mem_flat;
  logic                       w_idle;
  logic                       w_wr_ok;
  logic                       w_rsv_ok;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_wr_ok  = w_idle && wr_en && addr_in_range(32'(wr_addr), 32'(NUM_REGS));
  assign w_rsv_ok = w_idle && rsv_en && addr_in_range(32'(rsv_addr), 32'(NUM_REGS));

  // Sweep FSM: CLEAR walks ptr over every register, IDLE waits for clr_req.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == LAST_PTR) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end else begin
            r_state <= ST_CLEAR;
            r_ptr   <= r_ptr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          r_state <= clr_req ? ST_CLEAR : ST_IDLE;
          r_ptr   <= '0;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Reset-less storage so it maps onto distributed RAM; the sweep provides the zeroing.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_CLEAR)) begin
      r_mem[r_ptr] <= '0;
    end else if (!reset && w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Pending-write scoreboard; the reserve update comes last so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else if (w_idle && clr_req) begin
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_mem_flat[g*DATA_W +: DATA_W] = r_mem[g];
  end

  assign ready  = w_idle;
  assign result = w_idle ? r_mem[RESULT_IDX] : '0;

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS)
  ) u_port_a (
    .i_ready   (w_idle),
    .i_rd_en   (rd_en_a),
    .i_rd_addr (rd_addr_a),
    .i_mem_flat(w_mem_flat),
    .i_busy    (r_busy),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rsv_en  (rsv_en),
    .i_rsv_addr(rsv_addr),
    .o_rd_data (rd_data_a),
    .o_busy    (busy_a)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .BYPASS  (BYPASS)
  ) u_port_b (
    .i_ready   (w_idle),
    .i_rd_en   (rd_en_b),
    .i_rd_addr (rd_addr_b),
    .i_mem_flat(w_mem_flat),
    .i_busy    (r_busy),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rsv_en  (rsv_en),
    .i_rsv_addr(rsv_addr),
    .o_rd_data (rd_data_b),
    .o_busy    (busy_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: drives three configurations with shared stimulus
//   dut0: 8 x 16, bypass on   dut1: 8 x 16, bypass off   dut2: 6 x 32, bypass on
// Expected outputs come from a countdown/array model and are queued per cycle;
// a negedge monitor pops and compares.
module tb_regfile_2r1w;

  typedef struct packed {
    logic        rdy;
    logic        ba;
    logic        bb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } obs_t;
  typedef obs_t [2:0] obs3_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, wr_en, rsv_en, rd_en_a, rd_en_b, clr_req;
  logic [2:0]  wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data;

  logic        rdy0, ba0, bb0, rdy1, ba1, bb1, rdy2, ba2, bb2;
  logic [15:0] a0, b0, res0, a1, b1, res1;
  logic [31:0] a2, b2, res2;

  regfile_2r1w #(.DATA_W(16), .NUM_REGS(8), .RESULT_IDX(3), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a0), .busy_a(ba0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b0), .busy_b(bb0),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .ready(rdy0), .result(res0));

  regfile_2r1w #(.DATA_W(16), .NUM_REGS(8), .RESULT_IDX(3), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a1), .busy_a(ba1),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b1), .busy_b(bb1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .ready(rdy1), .result(res1));

  regfile_2r1w #(.DATA_W(32), .NUM_REGS(6), .RESULT_IDX(3), .BYPASS(1)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(a2), .busy_a(ba2),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(b2), .busy_b(bb2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .ready(rdy2), .result(res2));

  // Reference model: per configuration, register contents, pending flags and
  // the number of sweep cycles still to run (0 means the file is usable).
  int          nregs [3] = '{8, 8, 6};
  int          byp   [3] = '{1, 0, 1};
  logic [31:0] mask  [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [31:0] m_mem  [3][8];
  logic        m_busy [3][8];
  int          m_left [3];

  obs3_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input int d, input logic [31:0] act,
                              input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, expv, $time);
    end
  endfunction

  function automatic void port_exp(input int d, input logic en, input logic [2:0] addr,
                                   output logic [31:0] data, output logic bsy);
    data = 32'h0;
    bsy  = 1'b0;
    if (int'(addr) < nregs[d]) begin
      if (byp[d] != 0 && wr_en && wr_addr == addr) begin
        data = en ? (wr_data & mask[d]) : 32'h0;
        bsy  = rsv_en && (rsv_addr == addr);
      end else begin
        data = en ? m_mem[d][addr] : 32'h0;
        bsy  = m_busy[d][addr];
      end
    end
  endfunction

  function automatic obs_t model_out(input int d);
    obs_t o;
    o = '0;
    if (m_left[d] == 0) begin
      o.rdy = 1'b1;
      o.res = m_mem[d][3];
      port_exp(d, rd_en_a, rd_addr_a, o.a, o.ba);
      port_exp(d, rd_en_b, rd_addr_b, o.b, o.bb);
    end
    return o;
  endfunction

  function automatic void model_wipe(input int d);
    m_left[d] = nregs[d];
    for (int i = 0; i < 8; i++) begin
      m_mem[d][i]  = 32'h0;
      m_busy[d][i] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input int d);
    if (reset) begin
      model_wipe(d);
    end else if (m_left[d] > 0) begin
      m_left[d]--;
    end else if (clr_req) begin
      model_wipe(d);
    end else begin
      if (wr_en && int'(wr_addr) < nregs[d]) begin
        m_mem[d][wr_addr]  = wr_data & mask[d];
        m_busy[d][wr_addr] = 1'b0;
      end
      if (rsv_en && int'(rsv_addr) < nregs[d]) m_busy[d][rsv_addr] = 1'b1;
    end
  endfunction

  // One cycle: apply inputs, queue the expected outputs, advance model at the edge.
  task automatic step(input logic rst, input logic clr, input logic we, input logic [2:0] wa,
                      input logic [31:0] wd, input logic rea, input logic [2:0] aa,
                      input logic reb, input logic [2:0] ab, input logic rv,
                      input logic [2:0] rva);
    obs3_t e;
    reset = rst; clr_req = clr; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en_a = rea; rd_addr_a = aa; rd_en_b = reb; rd_addr_b = ab;
    rsv_en = rv; rsv_addr = rva;
    for (int d = 0; d < 3; d++) e[d] = model_out(d);
    exp_q.push_back(e);
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
  endtask

  task automatic rd(input logic [2:0] aa, input logic [2:0] ab);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, aa, 1'b1, ab, 1'b0, 3'd0);
  endtask

  // Monitor: compare DUT outputs against the queued expectation away from the edge.
  always @(negedge clk) begin
    obs3_t e;
    obs3_t act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act[0] = '{rdy0, ba0, bb0, {16'h0, a0}, {16'h0, b0}, {16'h0, res0}};
      act[1] = '{rdy1, ba1, bb1, {16'h0, a1}, {16'h0, b1}, {16'h0, res1}};
      act[2] = '{rdy2, ba2, bb2, a2, b2, res2};
      for (int d = 0; d < 3; d++) begin
        chk("ready",     d, {31'h0, act[d].rdy}, {31'h0, e[d].rdy});
        chk("busy_a",    d, {31'h0, act[d].ba},  {31'h0, e[d].ba});
        chk("busy_b",    d, {31'h0, act[d].bb},  {31'h0, e[d].bb});
        chk("rd_data_a", d, act[d].a,   e[d].a);
        chk("rd_data_b", d, act[d].b,   e[d].b);
        chk("result",    d, act[d].res, e[d].res);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'h0;
    rd_en_a = 1'b1; rd_addr_a = 3'd0; rd_en_b = 1'b1; rd_addr_b = 3'd0;
    rsv_en = 1'b0; rsv_addr = 3'd0;
    for (int d = 0; d < 3; d++) model_wipe(d);
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
    // Second reset cycle, then release and watch the sweep finish.
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) rd(3'(i), 3'(7 - i));
    // Write R3 with same-cycle read (bypass vs no bypass), then result tap.
    step(1'b0, 1'b0, 1'b1, 3'd3, 32'h0000_BEEF, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0);
    rd(3'd3, 3'd0);
    // Reserve R5, then write it, then reserve+write R2 together.
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 3'd5);
    rd(3'd5, 3'd5);
    step(1'b0, 1'b0, 1'b1, 3'd5, 32'h0000_1234, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 3'd0);
    rd(3'd5, 3'd5);
    step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0000_2222, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd2);
    rd(3'd2, 3'd2);
    // Dual-port read of R1/R6, then port B disabled.
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0011, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 3'd6, 32'h0000_0066, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0);
    rd(3'd1, 3'd6);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 1'b0, 3'd6, 1'b0, 3'd0);
    // Clear sweep with an ignored mid-sweep write and reserve.
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 1'b1, 3'd5, 1'b0, 3'd0);
    step(1'b0, 1'b0, 1'b1, 3'd4, 32'h0000_4444, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 3'd4);
    for (int i = 0; i < 9; i++) rd(3'd3, 3'd4);
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));
    // Reset in the middle of a sweep restarts it.
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) rd(3'd3, 3'd2);
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 1'b1, 3'd2, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) rd(3'd3, 3'd2);
    // Holes above NUM_REGS on the 6-deep file; wide data on R5.
    step(1'b0, 1'b0, 1'b1, 3'd7, 32'hDEAD_BEEF, 1'b1, 3'd7, 1'b1, 3'd5, 1'b1, 3'd7);
    step(1'b0, 1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 1'b1, 3'd7, 1'b1, 3'd5, 1'b0, 3'd0);
    rd(3'd7, 3'd5);
    // Randomized traffic, biased so reads often hit the written address.
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  wa;
      logic [2:0]  aa;
      logic [2:0]  ab;
      logic [2:0]  ra;
      wa = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      aa = ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7));
      ab = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 47) == 0),
           ($urandom_range(0, 1) == 1), wa, $urandom,
           ($urandom_range(0, 5) != 0), aa, ($urandom_range(0, 5) != 0), ab,
           ($urandom_range(0, 3) == 0), ra);
    end
    reset = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
